nios_system_onchip_mem_arbiter: RTL and testbench

//  Shares the single-port on-chip RAM (32-bit words, 15-bit word address, 31250 words, 1-cycle read)

---
 rtl/nios_system_onchip_mem_arbiter_pkg.sv | 25 ++
 rtl/nios_system_onchip_mem_arbiter_if.sv | 33 +++
 rtl/nios_system_onchip_mem_arbiter_rr_arb2.sv | 40 ++++
 rtl/nios_system_onchip_mem_arbiter.sv | 98 +++++++++
 tb/tb_nios_system_onchip_mem_arbiter.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/nios_system_onchip_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nios_mem_arb_pkg
// Purpose  : Shared sizes, grant tag type and address range helper for the
//            on-chip RAM arbiter.
// Contents : ADDR_W, DATA_W, BE_W, NUM_WORDS, gnt_e, addr_in_range()
// Revision : 1.0 - initial release
// ============================================================================
package nios_mem_arb_pkg;

  localparam int ADDR_W    = 15;
  localparam int DATA_W    = 32;
  localparam int BE_W      = DATA_W / 8;
  localparam int NUM_WORDS = 31250;

  // Identifies a master; used both for the last grant and the read tag.
  typedef enum logic {GNT_M0 = 1'b0, GNT_M1 = 1'b1} gnt_e;

  // Only the first NUM_WORDS words of the address space are populated.
  function automatic logic addr_in_range(logic [ADDR_W-1:0] addr);
    return addr < ADDR_W'(NUM_WORDS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/nios_system_onchip_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : nios_system_onchip_mem_arbiter_if
// Purpose  : Avalon-MM master bundle between one master and the arbiter.
// Ports    : address, byteenable, read, write, writedata  (master -> arbiter)
//            waitrequest, readdata, readdatavalid         (arbiter -> master)
// Modports : master (the requesting side), slave (the arbiter side)
// Revision : 1.0 - initial release
// ============================================================================
interface nios_system_onchip_mem_arbiter_if;
  import nios_mem_arb_pkg::*;

  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );

endinterface
`default_nettype wire

// File: rtl/nios_system_onchip_mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : onchip_mem_rr_arb2
// Purpose  : Two-way combinational grant with a last-grant register.
// Ports    : clk, reset (sync, active-high), req[1:0] in, gnt[1:0] one-hot out
// Params   : ROUND_ROBIN 1 = alternate on contention, 0 = m0 always wins
// Revision : 1.0 - initial release
// ============================================================================
module onchip_mem_rr_arb2
  import nios_mem_arb_pkg::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  gnt_e last_grant;

  // A lone requester always wins; on contention favour the master that was
  // not granted last (or m0 unconditionally in fixed-priority mode).
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      if (ROUND_ROBIN != 0 && last_grant == GNT_M0) gnt = 2'b10;
      else                                            gnt = 2'b01;
    end
  end

  // Reset to m1 so m0 wins the first contention after reset.
  always_ff @(posedge clk) begin
    if (reset)       last_grant <= GNT_M1;
    else if (gnt[0]) last_grant <= GNT_M0;
    else if (gnt[1]) last_grant <= GNT_M1;
  end

endmodule
`default_nettype wire

// File: rtl/nios_system_onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : nios_system_onchip_mem_arbiter
// Purpose  : Shares a single-port 1-cycle-read on-chip RAM between two
//            Avalon-MM masters, returns read data to the issuing master and
//            traps out-of-range accesses.
// Ports    : clk, reset     clock and synchronous active-high reset
//            m0, m1         master buses (slave modport)
//            mem_*          RAM port; mem_readdata valid 1 cycle after address
//            oor_flag       sticky out-of-range indicator, cleared by reset
// Params   : ROUND_ROBIN    1 = alternate on contention, 0 = m0 priority
// Revision : 1.0 - initial release
// ============================================================================
module nios_system_onchip_mem_arbiter
  import nios_mem_arb_pkg::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  nios_system_onchip_mem_arbiter_if.slave m0,
  nios_system_onchip_mem_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]           mem_address,
  output logic [BE_W-1:0]             mem_byteenable,
  output logic                        mem_chipselect,
  output logic                        mem_write,
  output logic [DATA_W-1:0]           mem_writedata,
  output logic                        mem_clken,
  input  logic [DATA_W-1:0]           mem_readdata,
  output logic                        oor_flag
);

  logic [1:0] req;
  logic [1:0] gnt;
  logic       sel_m1;
  logic       granted;
  logic       gnt_write;
  logic       gnt_read;
  logic       in_range;

  // Read pipeline: one stage matching the RAM read latency.
  logic       rd_vld;
  gnt_e       rd_tag;
  logic       rd_oor;

  // Requests are masked during reset so nothing is granted then.
  assign req = {~reset & (m1.read | m1.write), ~reset & (m0.read | m0.write)};

  onchip_mem_rr_arb2 #(
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .gnt   (gnt)
  );

  assign sel_m1    = gnt[1];
  assign granted   = |gnt;
  // read+write together counts as a write.
  assign gnt_write = sel_m1 ? m1.write : m0.write;
  assign gnt_read  = (sel_m1 ? m1.read : m0.read) & ~gnt_write;

  // With no grant, m0's fields pass through; chipselect keeps them inert.
  assign mem_address    = sel_m1 ? m1.address    : m0.address;
  assign mem_byteenable = sel_m1 ? m1.byteenable : m0.byteenable;
  assign mem_writedata  = sel_m1 ? m1.writedata  : m0.writedata;
  assign in_range       = addr_in_range(mem_address);
  assign mem_chipselect = granted & in_range;
  assign mem_write      = mem_chipselect & gnt_write;
  assign mem_clken      = 1'b1;

  assign m0.waitrequest = ~gnt[0];
  assign m1.waitrequest = ~gnt[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld   <= 1'b0;
      rd_tag   <= GNT_M0;
      rd_oor   <= 1'b0;
      oor_flag <= 1'b0;
    end else begin
      rd_vld <= granted & gnt_read;
      rd_tag <= sel_m1 ? GNT_M1 : GNT_M0;
      rd_oor <= ~in_range;
      if (granted && !in_range) oor_flag <= 1'b1;
    end
  end

  // Gating with reset drops a read already in flight when reset arrives.
  assign m0.readdatavalid = rd_vld & (rd_tag == GNT_M0) & ~reset;
  assign m1.readdatavalid = rd_vld & (rd_tag == GNT_M1) & ~reset;
  // Out-of-range reads return zero instead of whatever the RAM drives.
  assign m0.readdata = (m0.readdatavalid && !rd_oor) ? mem_readdata : '0;
  assign m1.readdata = (m1.readdatavalid && !rd_oor) ? mem_readdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_nios_system_onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_nios_system_onchip_mem_arbiter
// Purpose  : Directed, table-driven bench for the on-chip RAM arbiter with
//            round-robin (u_dut1) and fixed-priority (u_dut2) instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nios_system_onchip_mem_arbiter;
  import nios_mem_arb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  initial forever #5 clk = ~clk;

  nios_system_onchip_mem_arbiter_if a0 ();
  nios_system_onchip_mem_arbiter_if a1 ();
  nios_system_onchip_mem_arbiter_if b0 ();
  nios_system_onchip_mem_arbiter_if b1 ();

  logic [ADDR_W-1:0] addr1, addr2;
  logic [BE_W-1:0]   be1, be2;
  logic              cs1, cs2, we1, we2, ck1, ck2, oor1, oor2;
  logic [DATA_W-1:0] wd1, wd2, rd1, rd2;

  nios_system_onchip_mem_arbiter #(.ROUND_ROBIN(1)) u_dut1 (
    .clk(clk), .reset(reset), .m0(a0), .m1(a1),
    .mem_address(addr1), .mem_byteenable(be1), .mem_chipselect(cs1),
    .mem_write(we1), .mem_writedata(wd1), .mem_clken(ck1),
    .mem_readdata(rd1), .oor_flag(oor1)
  );

  nios_system_onchip_mem_arbiter #(.ROUND_ROBIN(0)) u_dut2 (
    .clk(clk), .reset(reset), .m0(b0), .m1(b1),
    .mem_address(addr2), .mem_byteenable(be2), .mem_chipselect(cs2),
    .mem_write(we2), .mem_writedata(wd2), .mem_clken(ck2),
    .mem_readdata(rd2), .oor_flag(oor2)
  );

  // RAM model for u_dut1: 1-cycle registered read, byte-lane writes.
  // Unpopulated addresses read a distinctive non-zero pattern.
  logic [DATA_W-1:0] ram1 [0:32767];
  always @(posedge clk) begin
    if (cs1 && we1)
      for (int b = 0; b < BE_W; b++)
        if (be1[b]) ram1[addr1][8*b +: 8] <= wd1[8*b +: 8];
    rd1 <= (addr1 >= ADDR_W'(NUM_WORDS)) ? 32'hBADBAD00 : ram1[addr1];
  end

  // Read-only pattern RAM for u_dut2.
  always @(posedge clk) rd2 <= {16'hA5A5, 1'b0, addr2};

  int checks = 0;
  int failures = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(logic r0, logic w0, logic [14:0] ad0, logic [31:0] d0,
                        logic r1, logic w1, logic [14:0] ad1, logic [31:0] d1);
    a0.read = r0; a0.write = w0; a0.address = ad0; a0.writedata = d0; a0.byteenable = 4'hF;
    a1.read = r1; a1.write = w1; a1.address = ad1; a1.writedata = d1; a1.byteenable = 4'hF;
  endtask

  task automatic drive2(logic r0, logic [14:0] ad0, logic r1, logic [14:0] ad1);
    b0.read = r0; b0.write = 1'b0; b0.address = ad0; b0.writedata = '0; b0.byteenable = 4'hF;
    b1.read = r1; b1.write = 1'b0; b1.address = ad1; b1.writedata = '0; b1.byteenable = 4'hF;
  endtask

  // Inputs applied in a cycle; waitrequest/mem_* expectations refer to that
  // cycle, readdatavalid/readdata/oor to the access of the previous cycle.
  typedef struct {
    logic        m0_rd, m0_wr;
    logic [14:0] m0_addr;
    logic [31:0] m0_wd;
    logic        m1_rd, m1_wr;
    logic [14:0] m1_addr;
    logic [31:0] m1_wd;
    logic        w0, w1, v0, v1;
    logic [31:0] rdata;
    logic        cs, we, oor;
  } vec_t;

  vec_t vecs [15];

  initial begin
    vecs[0]  = '{0,0,15'h0000,32'h0, 0,0,15'h0000,32'h0, 1,1,0,0, 32'h0, 0,0,0};
    vecs[1]  = '{0,1,15'h0010,32'hDEADBEEF, 0,0,15'h0000,32'h0, 0,1,0,0, 32'h0, 1,1,0};
    vecs[2]  = '{1,0,15'h0010,32'h0, 0,0,15'h0000,32'h0, 0,1,0,0, 32'h0, 1,0,0};
    vecs[3]  = '{0,0,15'h0000,32'h0, 0,0,15'h0000,32'h0, 1,1,1,0, 32'hDEADBEEF, 0,0,0};
    vecs[4]  = '{0,0,15'h0000,32'h0, 0,1,15'h0020,32'hCAFEF00D, 1,0,0,0, 32'h0, 1,1,0};
    vecs[5]  = '{1,0,15'h0010,32'h0, 1,0,15'h0020,32'h0, 0,1,0,0, 32'h0, 1,0,0};
    vecs[6]  = '{1,0,15'h0010,32'h0, 1,0,15'h0020,32'h0, 1,0,1,0, 32'hDEADBEEF, 1,0,0};
    vecs[7]  = '{1,0,15'h0010,32'h0, 1,0,15'h0020,32'h0, 0,1,0,1, 32'hCAFEF00D, 1,0,0};
    vecs[8]  = '{1,0,15'h0010,32'h0, 1,0,15'h0020,32'h0, 1,0,1,0, 32'hDEADBEEF, 1,0,0};
    vecs[9]  = '{1,0,15'h0010,32'h0, 1,0,15'h0020,32'h0, 0,1,0,1, 32'hCAFEF00D, 1,0,0};
    vecs[10] = '{1,0,15'h0010,32'h0, 1,0,15'h0020,32'h0, 1,0,1,0, 32'hDEADBEEF, 1,0,0};
    vecs[11] = '{0,0,15'h0000,32'h0, 0,0,15'h0000,32'h0, 1,1,0,1, 32'hCAFEF00D, 0,0,0};
    vecs[12] = '{0,0,15'h0000,32'h0, 0,1,15'h7A12,32'h12345678, 1,0,0,0, 32'h0, 0,0,0};
    vecs[13] = '{0,0,15'h0000,32'h0, 1,0,15'h7A12,32'h0, 1,0,0,0, 32'h0, 0,0,1};
    vecs[14] = '{0,0,15'h0000,32'h0, 0,0,15'h0000,32'h0, 1,1,0,1, 32'h0, 0,0,1};

    reset = 1'b1;
    drive1(0,0,0,0, 0,0,0,0);
    drive2(0,0, 0,0);

    // Reset held 3 cycles with idle masters.
    for (int k = 0; k < 3; k++) begin
      tick();
      #3;
      check($sformatf("rst%0d wait0", k), 32'(a0.waitrequest), 32'd1);
      check($sformatf("rst%0d wait1", k), 32'(a1.waitrequest), 32'd1);
      check($sformatf("rst%0d rdv0", k), 32'(a0.readdatavalid), 32'd0);
      check($sformatf("rst%0d rdv1", k), 32'(a1.readdatavalid), 32'd0);
      check($sformatf("rst%0d oor", k), 32'(oor1), 32'd0);
      check($sformatf("rst%0d cs", k), 32'(cs1), 32'd0);
      check($sformatf("rst%0d rdata0", k), a0.readdata, 32'h0);
    end
    tick();
    reset = 1'b0;

    // Table: write/read, round-robin contention, out-of-range access.
    for (int i = 0; i < 15; i++) begin
      drive1(vecs[i].m0_rd, vecs[i].m0_wr, vecs[i].m0_addr, vecs[i].m0_wd,
             vecs[i].m1_rd, vecs[i].m1_wr, vecs[i].m1_addr, vecs[i].m1_wd);
      #3;
      check($sformatf("v%0d wait0", i), 32'(a0.waitrequest), 32'(vecs[i].w0));
      check($sformatf("v%0d wait1", i), 32'(a1.waitrequest), 32'(vecs[i].w1));
      check($sformatf("v%0d rdv0", i), 32'(a0.readdatavalid), 32'(vecs[i].v0));
      check($sformatf("v%0d rdv1", i), 32'(a1.readdatavalid), 32'(vecs[i].v1));
      check($sformatf("v%0d cs", i), 32'(cs1), 32'(vecs[i].cs));
      check($sformatf("v%0d we", i), 32'(we1), 32'(vecs[i].we));
      check($sformatf("v%0d oor", i), 32'(oor1), 32'(vecs[i].oor));
      if (vecs[i].v0) check($sformatf("v%0d rdata0", i), a0.readdata, vecs[i].rdata);
      if (vecs[i].v1) check($sformatf("v%0d rdata1", i), a1.readdata, vecs[i].rdata);
      tick();
    end

    // Fixed priority: m0 wins every contended cycle for 6 cycles.
    drive1(0,0,0,0, 0,0,0,0);
    for (int k = 0; k < 7; k++) begin
      if (k < 6) drive2(1, 15'h0005, 1, 15'h0006);
      else       drive2(0, 15'h0000, 0, 15'h0000);
      #3;
      if (k < 6) begin
        check($sformatf("fp%0d wait0", k), 32'(b0.waitrequest), 32'd0);
        check($sformatf("fp%0d wait1", k), 32'(b1.waitrequest), 32'd1);
        check($sformatf("fp%0d addr", k), 32'(addr2), 32'h5);
      end
      check($sformatf("fp%0d rdv0", k), 32'(b0.readdatavalid), (k > 0) ? 32'd1 : 32'd0);
      check($sformatf("fp%0d rdv1", k), 32'(b1.readdatavalid), 32'd0);
      if (k > 0) check($sformatf("fp%0d rdata0", k), b0.readdata, 32'hA5A50005);
      tick();
    end
    drive2(0,0, 0,0);

    // Reset arriving the cycle after a granted read discards it.
    drive1(1,0,15'h0010,0, 0,0,0,0);
    #3;
    check("rr wait0", 32'(a0.waitrequest), 32'd0);
    tick();
    reset = 1'b1;
    drive1(0,0,0,0, 0,0,0,0);
    #3;
    check("rr rdv0 in reset", 32'(a0.readdatavalid), 32'd0);
    tick();
    drive1(1,0,15'h0010,0, 1,0,15'h0020,0);
    #3;
    check("rr wait0 in reset", 32'(a0.waitrequest), 32'd1);
    check("rr wait1 in reset", 32'(a1.waitrequest), 32'd1);
    check("rr rdv0 after reset edge", 32'(a0.readdatavalid), 32'd0);
    tick();
    reset = 1'b0;
    #3;
    check("rr first contention wait0", 32'(a0.waitrequest), 32'd0);
    check("rr first contention wait1", 32'(a1.waitrequest), 32'd1);
    check("rr oor cleared", 32'(oor1), 32'd0);
    tick();
    #3;
    check("rr second contention wait0", 32'(a0.waitrequest), 32'd1);
    check("rr second contention wait1", 32'(a1.waitrequest), 32'd0);
    check("rr rdv0", 32'(a0.readdatavalid), 32'd1);
    check("rr rdata0", a0.readdata, 32'hDEADBEEF);
    tick();
    drive1(0,0,0,0, 0,0,0,0);
    #3;
    check("rr rdv1", 32'(a1.readdatavalid), 32'd1);
    check("rr rdv0 off", 32'(a0.readdatavalid), 32'd0);
    check("rr rdata1", a1.readdata, 32'hCAFEF00D);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
